ghost_chaser: RTL

//  Parametrised enemy sprite that chases a target (Yoshi) within a configurable screen zone,

---
 rtl/ghost_chaser.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ghost_chaser.sv
// Enemy sprite that chases a target inside a screen zone, walks home when the
// target leaves, and can be frozen for a fixed number of steps.
module ghost_chaser #(
  parameter int          T_W          = 16,
  parameter int          HOME_X       = 620,
  parameter int          HOME_Y       = 460,
  parameter int          ZONE_Y_MIN   = 297,
  parameter int          ZONE_Y_MAX   = 479,
  parameter int          BASE_PERIOD  = 4600000,
  parameter int          MIN_PERIOD   = 500000,
  parameter int          ANIM_PERIOD  = 40000000,
  parameter int          FREEZE_TICKS = 64,
  parameter logic [11:0] TRANSP       = 12'h6DE,
  localparam int         COL_W        = $clog2(T_W),
  localparam int         ROW_W        = $clog2(2 * T_W),
  localparam int         ADDR_W       = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic [9:0]        tgt_x,
  input  logic [9:0]        tgt_y,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [25:0]       speed_offset,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              dir,
  output logic [1:0]        state,
  output logic              sprite_on,
  output logic [11:0]       rgb_out
);

  localparam int         PER_W = 27;
  localparam int         AN_W  = $clog2(ANIM_PERIOD);
  localparam int         FC_W  = $clog2(FREEZE_TICKS) + 1;
  localparam logic [9:0] HX    = 10'(HOME_X);
  localparam logic [9:0] HY    = 10'(HOME_Y);

  typedef enum logic [1:0] {
    S_HOME   = 2'b00,
    S_CHASE  = 2'b01,
    S_RETURN = 2'b10,
    S_FROZEN = 2'b11
  } state_t;

  state_t           cur_st;
  state_t           nxt_st;
  logic [FC_W-1:0]  frz_cnt;
  logic [FC_W-1:0]  frz_cnt_nxt;
  logic [PER_W-1:0] step_cnt;
  logic [PER_W-1:0] period;
  logic             tick;
  logic             in_zone;
  logic             has_goal;
  logic [9:0]       goal_x;
  logic [9:0]       goal_y;
  logic [AN_W-1:0]  anim_cnt;
  logic             frame;
  logic [10:0]      x_lim;
  logic [10:0]      y_lim;
  logic [9:0]       dx;
  logic [9:0]       dy;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_box_p0;
  logic             in_box_p1;

  // Step period shrinks with speed_offset but never drops below MIN_PERIOD.
  function automatic logic [PER_W-1:0] sat_period(input logic [25:0] off);
    logic [PER_W-1:0] base_p;
    logic [PER_W-1:0] min_p;
    logic [PER_W-1:0] off_w;
    base_p = PER_W'(BASE_PERIOD);
    min_p  = PER_W'(MIN_PERIOD);
    off_w  = {1'b0, off};
    if (off_w + min_p >= base_p) sat_period = min_p;
    else                         sat_period = base_p - off_w;
  endfunction

  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] goal);
    logic signed [10:0] diff;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    if (diff > 11'sd0)      step_toward = cur + 10'd1;
    else if (diff < 11'sd0) step_toward = cur - 10'd1;
    else                    step_toward = cur;
  endfunction

  // A shortened period takes effect at once: an overshooting count ticks and wraps.
  assign period = sat_period(speed_offset);
  assign tick   = (step_cnt >= period - PER_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n)  step_cnt <= '0;
    else if (tick) step_cnt <= '0;
    else           step_cnt <= step_cnt + PER_W'(1);
  end

  assign in_zone  = (tgt_y >= 10'(ZONE_Y_MIN)) && (tgt_y <= 10'(ZONE_Y_MAX));
  assign has_goal = (cur_st == S_CHASE) || (cur_st == S_RETURN);
  assign goal_x   = (cur_st == S_CHASE) ? tgt_x : HX;
  assign goal_y   = (cur_st == S_CHASE) ? tgt_y : HY;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_st  <= S_HOME;
      frz_cnt <= '0;
    end else begin
      cur_st  <= nxt_st;
      frz_cnt <= frz_cnt_nxt;
    end
  end

  always_comb begin
    nxt_st      = cur_st;
    frz_cnt_nxt = frz_cnt;
    if (freeze) begin
      nxt_st      = S_FROZEN;
      frz_cnt_nxt = '0;
    end else begin
      case (cur_st)
        S_HOME:   if (in_zone) nxt_st = S_CHASE;
        S_CHASE:  if (!in_zone) nxt_st = S_RETURN;
        S_RETURN: begin
          if (in_zone)                          nxt_st = S_CHASE;
          else if (pos_x == HX && pos_y == HY) nxt_st = S_HOME;
        end
        S_FROZEN: begin
          if (tick) begin
            if (frz_cnt == FC_W'(FREEZE_TICKS - 1)) begin
              nxt_st      = in_zone ? S_CHASE : S_RETURN;
              frz_cnt_nxt = '0;
            end else begin
              frz_cnt_nxt = frz_cnt + FC_W'(1);
            end
          end
        end
        default:  nxt_st = S_HOME;
      endcase
    end
  end

  assign state = cur_st;

  // Motion and facing use the state held before this edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_x <= HX;
      pos_y <= HY;
      dir   <= 1'b1;
    end else begin
      if (tick && has_goal) begin
        pos_x <= step_toward(pos_x, goal_x);
        pos_y <= step_toward(pos_y, goal_y);
      end
      if (has_goal) begin
        if (goal_x < pos_x)      dir <= 1'b0;
        else if (goal_x > pos_x) dir <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                               anim_cnt <= '0;
    else if (anim_cnt == AN_W'(ANIM_PERIOD - 1)) anim_cnt <= '0;
    else                                        anim_cnt <= anim_cnt + AN_W'(1);
  end

  assign frame = (anim_cnt >= AN_W'(ANIM_PERIOD / 2)) && (cur_st == S_CHASE);

  // Pixel stage p0: box test and ROM address from the live VGA coordinate.
  assign x_lim     = {1'b0, pos_x} + 11'(T_W);
  assign y_lim     = {1'b0, pos_y} + 11'(T_W);
  assign in_box_p0 = (x >= pos_x) && ({1'b0, x} < x_lim) &&
                     (y >= pos_y) && ({1'b0, y} < y_lim);
  assign dx        = x - pos_x;
  assign dy        = y - pos_y;
  assign col       = dir ? dx[COL_W-1:0] : COL_W'(T_W - 1) - dx[COL_W-1:0];
  assign row       = dy[ROW_W-1:0] + (frame ? ROW_W'(T_W) : ROW_W'(0));
  assign rom_addr  = {row, col};

  // Pixel stage p1: box flag aligned with the ROM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) in_box_p1 <= 1'b0;
    else          in_box_p1 <= in_box_p0;
  end

  assign sprite_on = in_box_p1 && (rom_data != TRANSP);
  assign rgb_out   = rom_data;

endmodule
